// File: rtl/shift_buffer_arbiter_pkg.sv
// Shared types and constants for the shift_buffer arbiter and its helpers.
package shift_buffer_arbiter_pkg;

    localparam int PKG_DATA_W         = 32;
    localparam int PKG_WORDS_PER_LINE = 8;

    // Arbiter states; the encoding is fixed for compatibility with older tooling.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_GRANT = 2'd1;
    localparam state_t ST_PAD   = 2'd2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_buffer_arbiter_rr_picker.sv
// Combinational round-robin search: first asserted valid bit at or after ptr, wrapping.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    int j;

    // Scan from the farthest candidate back to ptr so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (valid[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/shift_buffer_arbiter.sv
// Line-granular arbiter sharing one word-to-line packer between several word streams,
// with zero padding of a line whose owner stalls for too long.
module shift_buffer_arbiter
    import shift_buffer_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = PKG_DATA_W,
    parameter int WORDS_PER_LINE = PKG_WORDS_PER_LINE,
    parameter int TIMEOUT        = 16,
    parameter int OWN_W          = $clog2(NUM_REQ)
) (
    input  logic                      clk_data,
    input  logic                      rst,
    input  logic                      enable_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]         buf_data_o,
    output logic                      buf_wr_en_o,
    output logic                      line_done_o,
    output logic [OWN_W-1:0]          line_owner_o,
    output logic                      line_padded_o,
    output logic                      busy_o
);
    localparam int CNT_W  = cnt_w(WORDS_PER_LINE);
    localparam int IDLE_W = cnt_w(TIMEOUT);

    state_t            state;
    logic [OWN_W-1:0]  owner;
    logic [OWN_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  word_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              found;
    logic [OWN_W-1:0]  pick;
    logic [DATA_W-1:0] owner_word;
    logic              accept;
    logic              last_word;
    logic              timeout;

    rr_picker #(.N(NUM_REQ), .IDX_W(OWN_W)) u_picker (
        .valid (req_valid_i),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (pick)
    );

    always_comb begin
        req_ready_o = '0;
        if (state == ST_GRANT) req_ready_o[owner] = 1'b1;
    end

    assign owner_word   = req_data_i[int'(owner)*DATA_W +: DATA_W];
    assign accept       = req_ready_o[owner] & req_valid_i[owner];
    assign last_word    = (word_cnt == CNT_W'(WORDS_PER_LINE - 1));
    assign timeout      = (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign busy_o       = (state != ST_IDLE);
    assign line_owner_o = owner;

    always_ff @(posedge clk_data) begin
        if (rst) begin
            state         <= ST_IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            word_cnt      <= '0;
            idle_cnt      <= '0;
            buf_wr_en_o   <= 1'b0;
            buf_data_o    <= '0;
            line_done_o   <= 1'b0;
            line_padded_o <= 1'b0;
        end else begin
            // Write-side outputs are single-cycle pulses unless a branch below asserts them.
            buf_wr_en_o   <= 1'b0;
            buf_data_o    <= '0;
            line_done_o   <= 1'b0;
            line_padded_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable_i && found) begin
                        owner    <= pick;
                        rr_ptr   <= (pick == OWN_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                        word_cnt <= '0;
                        idle_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // An accept on the timeout cycle wins, so the line is not padded.
                    if (accept) begin
                        buf_wr_en_o <= 1'b1;
                        buf_data_o  <= owner_word;
                        word_cnt    <= word_cnt + 1'b1;
                        idle_cnt    <= '0;
                        if (last_word) begin
                            line_done_o <= 1'b1;
                            word_cnt    <= '0;
                            state       <= ST_IDLE;
                        end
                    end else if (timeout) begin
                        idle_cnt <= '0;
                        state    <= ST_PAD;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_PAD: begin
                    buf_wr_en_o <= 1'b1;
                    word_cnt    <= word_cnt + 1'b1;
                    if (last_word) begin
                        line_done_o   <= 1'b1;
                        line_padded_o <= 1'b1;
                        word_cnt      <= '0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_buffer_arbiter.sv
// Directed and random stimulus for shift_buffer_arbiter, scored against a line-level model.
module tb_shift_buffer_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int WL = 8;
    localparam int TO = 16;

    logic             clk_data = 1'b0;
    logic             rst;
    logic             enable_i;
    logic [NR-1:0]    req_valid_i;
    logic [NR*DW-1:0] req_data_i;
    logic [NR-1:0]    req_ready_o;
    logic [DW-1:0]    buf_data_o;
    logic             buf_wr_en_o;
    logic             line_done_o;
    logic [1:0]       line_owner_o;
    logic             line_padded_o;
    logic             busy_o;

    shift_buffer_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .WORDS_PER_LINE(WL), .TIMEOUT(TO)) dut (
        .clk_data      (clk_data),
        .rst           (rst),
        .enable_i      (enable_i),
        .req_valid_i   (req_valid_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .buf_data_o    (buf_data_o),
        .buf_wr_en_o   (buf_wr_en_o),
        .line_done_o   (line_done_o),
        .line_owner_o  (line_owner_o),
        .line_padded_o (line_padded_o),
        .busy_o        (busy_o)
    );

    always #5 clk_data = ~clk_data;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    int seq [NR];

    // Model: words per line, stall count, and a schedule of expected writes by future cycle.
    bit m_busy, m_pad;
    int m_rr, m_owner, m_cnt, m_stall, m_hold;
    bit          e_v    [16];
    logic [31:0] e_d    [16];
    bit          e_done [16];
    bit          e_padf [16];

    // Statistics of observed DUT traffic for the directed checks.
    int n_wr, n_zero, done_cnt, pad_lines, last_own, last_pad, first_wr, last_wr;

    function automatic logic [31:0] word(input int k, input int s);
        return (32'(k) << 24) | 32'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_pad = 0; m_rr = 0; m_owner = 0; m_cnt = 0; m_stall = 0; m_hold = 0;
        for (int i = 0; i < 16; i++) begin
            e_v[i] = 0; e_d[i] = '0; e_done[i] = 0; e_padf[i] = 0;
        end
    endtask

    task automatic stats_clear();
        n_wr = 0; n_zero = 0; first_wr = -1; last_wr = -1;
    endtask

    task automatic step_model();
        int left;
        chk("wr_en", 32'(buf_wr_en_o), 32'(e_v[0]));
        chk("data", buf_data_o, e_v[0] ? e_d[0] : 32'h0);
        chk("line_done", 32'(line_done_o), 32'(e_done[0]));
        chk("line_padded", 32'(line_padded_o), 32'(e_padf[0]));
        for (int i = 0; i < 15; i++) begin
            e_v[i] = e_v[i+1]; e_d[i] = e_d[i+1]; e_done[i] = e_done[i+1]; e_padf[i] = e_padf[i+1];
        end
        e_v[15] = 0; e_d[15] = '0; e_done[15] = 0; e_padf[15] = 0;
        if (buf_wr_en_o === 1'b1) begin
            n_wr++;
            if (buf_data_o == 0) n_zero++;
            if (first_wr < 0) first_wr = cyc_n;
            last_wr = cyc_n;
        end
        if (line_done_o === 1'b1) begin
            done_cnt++;
            last_own = int'(line_owner_o);
            last_pad = int'(line_padded_o);
            if (line_padded_o === 1'b1) pad_lines++;
        end
        if (m_pad) begin
            m_hold--;
            if (m_hold == 0) begin m_pad = 0; m_busy = 0; end
        end
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("ready", 32'(req_ready_o), (m_busy && !m_pad) ? (32'd1 << m_owner) : 32'd0);
        chk("line_owner", 32'(line_owner_o), 32'(m_owner));
        if (rst) begin
            model_clear();
        end else if (m_busy && !m_pad) begin
            if (req_valid_i[m_owner]) begin
                e_v[0] = 1; e_d[0] = word(m_owner, seq[m_owner]); e_done[0] = (m_cnt == WL-1);
                m_cnt++; m_stall = 0;
                if (m_cnt == WL) m_busy = 0;
            end else begin
                m_stall++;
                if (m_stall == TO) begin
                    // Zero writes for the rest of the line start two cycles later.
                    left = WL - m_cnt; m_pad = 1; m_hold = left + 1;
                    for (int i = 1; i <= left; i++) begin
                        e_v[i] = 1; e_d[i] = '0; e_done[i] = (i == left); e_padf[i] = (i == left);
                    end
                end
            end
        end else if (!m_busy && enable_i && (req_valid_i != 0)) begin
            for (int i = NR - 1; i >= 0; i--)
                if (req_valid_i[(m_rr + i) % NR]) m_owner = (m_rr + i) % NR;
            m_rr = (m_owner + 1) % NR; m_busy = 1; m_cnt = 0; m_stall = 0;
        end
    endtask

    task automatic cyc(input logic [NR-1:0] v, input logic en, input logic r);
        logic [NR-1:0] acc;
        req_valid_i = v; enable_i = en; rst = r;
        for (int k = 0; k < NR; k++) req_data_i[k*DW +: DW] = word(k, seq[k]);
        @(negedge clk_data);
        step_model();
        acc = r ? '0 : (req_valid_i & req_ready_o);
        @(posedge clk_data);
        #1;
        cyc_n++;
        for (int k = 0; k < NR; k++) if (acc[k]) seq[k]++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, p0, b;
        int quiet;
        logic [NR-1:0] v;
        for (int k = 0; k < NR; k++) seq[k] = 0;
        model_clear(); stats_clear(); done_cnt = 0; pad_lines = 0; last_own = -1; last_pad = -1;
        rst = 1; enable_i = 0; req_valid_i = '0; req_data_i = '0;
        repeat (2) @(posedge clk_data);
        #1;
        cyc('0, 1'b0, 1'b1);

        // Single requester, eight back-to-back words 0..7.
        stats_clear(); s0 = cyc_n; d0 = done_cnt;
        for (int i = 0; i < 14; i++) cyc((seq[0] < WL) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
        chk("t1_first_write", 32'(first_wr - s0), 32'd2);
        chk("t1_write_run", 32'(last_wr - first_wr), 32'd7);
        chk("t1_writes", 32'(n_wr), 32'd8);
        chk("t1_lines", 32'(done_cnt - d0), 32'd1);
        chk("t1_owner", 32'(last_own), 32'd0);
        chk("t1_padded", 32'(last_pad), 32'd0);

        // All requesters valid: owners rotate 0..3 from a fresh pointer.
        cyc('0, 1'b1, 1'b1);
        d0 = done_cnt;
        for (int i = 0; i < 60 && done_cnt < d0 + 4; i++) begin
            cyc(4'b1111, 1'b1, 1'b0);
            if (done_cnt > d0 && line_done_o === 1'b1)
                chk("t2_owner_order", 32'(last_own), 32'(done_cnt - d0 - 1));
        end
        chk("t2_lines", 32'(done_cnt - d0), 32'd4);
        repeat (40) cyc('0, 1'b1, 1'b0);

        // Requester 2 stalls after three words; the line is padded.
        stats_clear(); d0 = done_cnt; p0 = pad_lines; b = seq[2];
        for (int i = 0; i < 40; i++) cyc((seq[2] < b + 3) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
        chk("t3_writes", 32'(n_wr), 32'd8);
        chk("t3_zero_writes", 32'(n_zero), 32'd5);
        chk("t3_padded_lines", 32'(pad_lines - p0), 32'd1);
        chk("t3_owner", 32'(last_own), 32'd2);
        chk("t3_padded", 32'(last_pad), 32'd1);

        // Final word lands on the cycle the timeout would fire.
        d0 = done_cnt; p0 = pad_lines; b = seq[1];
        for (int i = 0; i < 20 && seq[1] < b + 7; i++) cyc(4'b0010, 1'b1, 1'b0);
        repeat (TO - 1) cyc('0, 1'b1, 1'b0);
        for (int i = 0; i < 3 && seq[1] < b + 8; i++) cyc(4'b0010, 1'b1, 1'b0);
        repeat (4) cyc('0, 1'b1, 1'b0);
        chk("t4_lines", 32'(done_cnt - d0), 32'd1);
        chk("t4_no_pad", 32'(pad_lines - p0), 32'd0);
        chk("t4_owner", 32'(last_own), 32'd1);

        // Reset after the fourth write of a line discards it and rewinds the pointer.
        d0 = done_cnt; b = seq[3];
        for (int i = 0; i < 20 && seq[3] < b + 4; i++) cyc(4'b1000, 1'b1, 1'b0);
        cyc(4'b1000, 1'b1, 1'b1);
        cyc('0, 1'b1, 1'b0);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        for (int i = 0; i < 30 && done_cnt == d0; i++) cyc(4'b1111, 1'b1, 1'b0);
        chk("t5_owner_after_rst", 32'(last_own), 32'd0);
        repeat (40) cyc('0, 1'b1, 1'b0);

        // Enable drops mid-line: the line finishes, then no more grants.
        d0 = done_cnt; stats_clear();
        for (int i = 0; i < 20 && n_wr < 3; i++) cyc(4'b1111, 1'b1, 1'b0);
        repeat (20) cyc(4'b1111, 1'b0, 1'b0);
        chk("t6_lines", 32'(done_cnt - d0), 32'd1);
        chk("t6_writes", 32'(n_wr), 32'd8);
        chk("t6_busy_low", 32'(busy_o), 32'd0);
        repeat (3) cyc(4'b1111, 1'b1, 1'b0);
        chk("t6_regrant", 32'(busy_o), 32'd1);
        repeat (40) cyc('0, 1'b1, 1'b0);

        // Random traffic with occasional quiet spells long enough to force padding.
        quiet = 0;
        for (int i = 0; i < 600; i++) begin
            if (quiet == 0 && $urandom_range(0, 39) == 0) quiet = 20;
            v = '0;
            if (quiet > 0) quiet--;
            else for (int k = 0; k < NR; k++) v[k] = ($urandom_range(0, 3) != 0);
            cyc(v, $urandom_range(0, 15) != 0, $urandom_range(0, 249) == 0);
        end
        repeat (40) cyc('0, 1'b1, 1'b0);
        chk("end_idle", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_buffer_arbiter.md
Name: shift_buffer_arbiter

Overview:
- Shares one 32-bit-in / 256-bit-out shift_buffer packer between NUM_REQ word-stream requesters.
- Grants the packer for a whole line of 8 words, so words from different requesters never interleave within a line.
- Drives the packer write port and reports, for each completed line, which requester owns it and whether it was zero-padded after a stall timeout.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 32, word width; must equal the packer input width.
- WORDS_PER_LINE, 8, words per packed line; must equal packer depth (256/32).
- TIMEOUT, 16, idle cycles of the granted requester before padding starts (>=1).

Ports:
- clk_data  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enable_i  in  1  permits new grants; does not abort a line in progress.
- req_valid_i  in  NUM_REQ  per-requester word valid.
- req_data_i  in  NUM_REQ*DATA_W  per-requester word; requester k occupies bits [k*DATA_W +: DATA_W].
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- buf_data_o  out  DATA_W  word to packer data_i.
- buf_wr_en_o  out  1  packer wr_en_i.
- line_done_o  out  1  one-cycle pulse on the final write of a line.
- line_owner_o  out  $clog2(NUM_REQ)  owner of the current/last line; valid with line_done_o.
- line_padded_o  out  1  qualifies line_done_o: line was completed with zero padding.
- busy_o  out  1  high in GRANT or PAD.

Behaviour:
- Reset (rst=1 at a clk_data edge): state IDLE; word_cnt=0; idle_cnt=0; rr_ptr=0; all outputs 0.
- Packer must be reset by the same rst, so packer count and arbiter count stay aligned.
- States: IDLE, GRANT, PAD.
- IDLE:
  - If enable_i and any req_valid_i, pick the first valid requester in round-robin order starting at rr_ptr.
  - Register it as owner; line_owner_o updates. Go to GRANT. Set rr_ptr = owner+1 mod NUM_REQ.
  - req_ready_o=0 while in IDLE.
- GRANT:
  - req_ready_o[owner]=1 combinationally; all other ready bits 0.
  - Accept = req_valid_i[owner] & req_ready_o[owner].
  - On accept: next cycle buf_wr_en_o=1 and buf_data_o = that word (one-cycle registered latency); word_cnt++; idle_cnt=0.
  - No accept: idle_cnt++.
  - On the accept with word_cnt==WORDS_PER_LINE-1: next state IDLE; line_done_o pulses together with that word's buf_wr_en_o.
  - If idle_cnt reaches TIMEOUT-1 with no accept this cycle: next state PAD.
- PAD:
  - req_ready_o=0.
  - Each cycle emit buf_wr_en_o=1 with buf_data_o=0 and word_cnt++.
  - On the final word: line_done_o=1, line_padded_o=1, then go to IDLE.
- Outside write cycles: buf_wr_en_o=0 and buf_data_o=0.
- Minimum inter-line gap: one IDLE cycle between the last accept and the next grant.
- Simultaneous final accept and timeout: the accept wins and the line is not padded.
- enable_i falling in GRANT/PAD: the current line completes normally; no new grant afterwards.
- Owner's valid dropping mid-line: the line stays locked to that owner (timeout handles stalls).
- A valid but ungranted requester sees ready=0 and holds its data; no starvation, since the round-robin pointer advances every line.
- Reset mid-line: the partial line is discarded; no line_done_o is generated.

Decomposition:
- Shared package: state enum (IDLE/GRANT/PAD); constants WORDS_PER_LINE=8, DATA_W=32; function to compute count width.
- Sub-module rr_picker: combinational round-robin first-one search from rr_ptr over req_valid_i, giving a found flag and index. Reusable by later arbiters.

Test Plan:
- Single requester: req 0 streams 8 words 0x0..0x7 back-to-back.
  - Required: buf_wr_en_o high 8 consecutive cycles, starting 2 cycles after req_valid rises.
  - Required: line_done_o on the 8th write, line_owner_o=0, line_padded_o=0.
- All 4 requesters continuously valid for 4 lines.
  - Required: owners 0,1,2,3 in order; no interleaved words; one IDLE gap cycle between lines.
- Req 2 sends 3 words, then drops valid (TIMEOUT=16).
  - Required: after 16 idle cycles, 5 zero writes follow.
  - Required: line_done_o with line_padded_o=1, owner=2.
- Final word accepted on the same cycle the timeout would fire.
  - Required: line_padded_o=0; no PAD writes.
- rst asserted after the 4th write of a line.
  - Required: all outputs 0 next cycle; no line_done_o; the next line starts with rr_ptr=0.
- enable_i deasserted mid-line while others are valid.
  - Required: the current line completes; busy_o falls; no further grants until enable_i returns.
